// File: rtl/spectrum_bar_buffer.sv
// spectrum_bar_buffer: squared float pair -> log2 bar height, double-buffered per frame for the display.
module spectrum_bar_buffer #(
  parameter int N         = 1024,
  parameter int fp_width  = 32,
  parameter int mag_width = 9,
  parameter int MAX_Y     = 480,
  parameter int INT_W     = 48
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         data_valid,
  input  logic                         sof,
  input  logic [fp_width-1:0]          real_sq_in,
  input  logic [fp_width-1:0]          imag_sq_in,
  input  logic [$clog2(N/2)-1:0]       rd_addr,
  output logic [mag_width-1:0]         rd_data,
  output logic                         bank_sel,
  output logic                         frame_done,
  output logic                         sync_err
);
  localparam int AW = $clog2(N/2);
  localparam int IW = $clog2(N);
  typedef enum logic {WAIT_SOF, FILL} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx, bin;
  logic accept, last, err, wbank;
  logic v0, v1, v2, b0, b1, b2, l0, l1, l2, w0, w1, w2;
  logic [AW-1:0] a0, a1, a2;
  logic [fp_width-1:0] re0, im0;
  logic [INT_W-1:0] cr1, ci1;
  logic [INT_W:0] sum2;
  logic [mag_width-1:0] bar;
  logic [mag_width-1:0] mem [N];

  function automatic logic [INT_W-1:0] f2i(input logic [fp_width-1:0] x);
    int e;
    logic [INT_W+23:0] t;
    e = int'(x[30:23]) - 127;
    t = {{INT_W{1'b0}}, 1'b1, x[22:0]} << e;
    return (e < 0) ? '0 : (x[30:23] == 8'hff || e >= INT_W) ? '1 : t[INT_W+22:23];
  endfunction

  function automatic logic [mag_width-1:0] bar_of(input logic [INT_W:0] s);
    int p, b;
    logic [INT_W:0] t;
    p = 0;
    for (int i = 0; i <= INT_W; i++) if (s[i]) p = i;
    t = s << (INT_W - p);
    b = 8 * p + int'(t[INT_W-1 -: 3]) + 1;
    b = (b > MAX_Y - 1) ? MAX_Y - 1 : b;
    return (s == '0) ? '0 : mag_width'(b);
  endfunction

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= WAIT_SOF;
    else     state <= state_n;

  always_comb state_n = (data_valid & sof) ? FILL : state;

  always_comb begin
    accept = data_valid & (sof | state == FILL);
    bin    = sof ? '0 : idx;
    last   = &bin;
    err    = data_valid & sof & state == FILL & idx != '0;
  end

  assign bar = bar_of(sum2);

  // wbank flips when the last sample enters, so the next frame is tagged for the new bank
  // while bank_sel only flips once that last sample has been written.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx        <= '0;
      wbank      <= 1'b0;
      v0         <= 1'b0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      bank_sel   <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      rd_data    <= '0;
    end else begin
      idx        <= accept ? bin + 1'b1 : idx;
      wbank      <= wbank ^ (accept & last);
      v0         <= accept;
      v1         <= v0;
      v2         <= v1;
      frame_done <= v2 & l2;
      bank_sel   <= bank_sel ^ (v2 & l2);
      sync_err   <= err;
      rd_data    <= mem[{~bank_sel, rd_addr}];
    end

  always_ff @(posedge clk) begin
    b0   <= wbank;
    l0   <= last;
    w0   <= ~bin[IW-1];
    a0   <= bin[AW-1:0];
    re0  <= real_sq_in;
    im0  <= imag_sq_in;
    b1   <= b0;
    l1   <= l0;
    w1   <= w0;
    a1   <= a0;
    cr1  <= f2i(re0);
    ci1  <= f2i(im0);
    b2   <= b1;
    l2   <= l1;
    w2   <= w1;
    a2   <= a1;
    sum2 <= {1'b0, cr1} + {1'b0, ci1};
    if (v2 & w2) mem[{b2, a2}] <= bar;
  end
endmodule

// File: doc/spectrum_bar_buffer.md
# spectrum_bar_buffer

Downstream of the real/imag squaring stage in the audio visualizer path. Accepts one pair of IEEE-754 single-precision squared components per bin and forms their sum in saturating fixed point. It converts the sum to a log2-scaled bar height of `mag_width` bits and stores the heights for the positive-frequency half of each N-point frame in a double-buffered bin memory. The VGA drawing logic reads a stable, completed frame from that memory while the next frame fills.

## Interface
Parameters:
- `N`, 1024: FFT points per frame; power of 2, ≥ 4.
- `fp_width`, 32: float width; only 32 supported.
- `mag_width`, 9: bar height width.
- `MAX_Y`, 480: screen height; bar clamps to `MAX_Y-1`.
- `INT_W`, 48: fixed-point integer width of each converted square.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous and active-high.
- `data_valid` in 1: one-cycle strobe; `real_sq_in`/`imag_sq_in` valid. Driven from the squaring stage done pulse.
- `sof` in 1: start of frame; meaningful only with `data_valid`; marks bin 0.
- `real_sq_in` in `fp_width`: real² float.
- `imag_sq_in` in `fp_width`: imag² float.
- `rd_addr` in log2(N/2): display read address.
- `rd_data` out `mag_width`: bar height at `rd_addr`, registered.
- `bank_sel` out 1: bank currently being written; the display bank is `~bank_sel`.
- `frame_done` out 1: one-cycle pulse marking a bank swap.
- `sync_err` out 1: one-cycle pulse marking a `sof` arriving mid-frame.

## Operation
- **FSM states:** WAIT_SOF (reset state) and FILL.
  - WAIT_SOF: samples with `sof=0` are discarded. `data_valid & sof` accepts the sample as bin 0 and moves to FILL.
  - FILL: every `data_valid` accepts a sample and increments bin index `idx` (log2(N) bits).
  - Sample `idx == N-1`: after its write completes, swap banks, pulse `frame_done`, set `idx` to 0, stay in FILL. The next frame needs no `sof`.
  - `data_valid & sof` with `idx != 0`: pulse `sync_err` and discard the partial frame (no swap, no `frame_done`). The sample is taken as bin 0 of a new frame in the same bank.
- **Float→fixed conversion, per input:**
  - Sign bit ignored.
  - exp==0: result 0 (zero and denormals).
  - exp==255: result 2^INT_W−1 (Inf/NaN).
  - e = exp−127. e<0 → 0. e≥INT_W → saturate to 2^INT_W−1. Otherwise floor(1.mant × 2^e).
- **Sum:** INT_W+1 bits, no overflow possible.
- **Bar height:**
  - sum==0 → 0.
  - Otherwise p = index of MSB (0..INT_W), f = the 3 bits directly below the MSB, zero-filled when p<3.
  - bar = min(8p+f+1, MAX_Y−1), result truncated to `mag_width`. With the defaults the maximum is 392.
- **Storage:**
  - Only bins idx < N/2 are written, to address idx in bank `bank_sel`. Bins ≥ N/2 are converted but not stored.
  - Each bank is N/2 × `mag_width`, contents uninitialized.
- **Read port:** always reads bank `~bank_sel`.

## Timing
- Pipeline accepts `data_valid` every cycle.
- Latency: sample strobed at edge t.
  - Stage 1 converts at t+1.
  - Stage 2 sums at t+2.
  - Stage 3 computes the bar and writes memory at t+3.
- Frame completion (sample N−1 strobed at t): `bank_sel` toggles and `frame_done` is high for the cycle following edge t+3.
- Each pipeline stage carries its own bank tag, so a new frame's samples entering during t+1..t+3 are written to the new bank.
- `sync_err` is high for the one cycle after the edge that samples the offending `sof`. Partial-frame samples still in the pipeline complete their writes.
- `rd_data` updates one edge after `rd_addr`. Across a swap, the read at the swap edge returns the old display bank; subsequent reads return the new one.
- Reset values (asynchronous, immediate):
  - `rd_data`=0, `bank_sel`=0, `frame_done`=0, `sync_err`=0.
  - FSM=WAIT_SOF, `idx`=0, pipeline valids cleared.
  - Memory contents are not reset.
- Reset mid-frame: in-flight samples are dropped and no swap occurs.

## Test plan
- **Reset:** assert `rst` mid-cycle → all outputs 0 immediately. `data_valid=1, sof=0` samples after release → no writes, no `frame_done`.
- **Basic conversion** (N=8): frame with bin0 real=0x41200000 (10.0), imag=0x41A00000 (20.0), other bins 0 → after `frame_done`, read addr 0 = 40, addrs 1–3 = 0.
- **Saturation/specials:** bin1 real=imag=0x7F800000 → 392. Bin2 real=0x3F000000 (0.5), imag=0 → 0. Bin3 real=0x3F800000 (1.0), imag=0 → 1.
- **Back-to-back frames:** 16 consecutive strobes, `sof` only on the first → two `frame_done` pulses exactly 8 cycles apart, `bank_sel` 0→1→0. The display shows frame 2 values after the second pulse.
- **Sync error:** `sof` at idx=5 → `sync_err` pulse, no `frame_done`, then 8 more samples → one `frame_done`. Stored values come from the post-`sof` frame.
- **Reset mid-frame:** `rst` after 4 samples → `bank_sel` stays 0, no `frame_done`. The next frame needs `sof`.
